fifo_stream_downsizer: RTL and testbench

Downstream consumer of the 128-bit first-word-fall-through FIFO. Pops one wide word at a time and serializes it into `RATIO = IN_WIDTH/OUT_WIDTH` narrow lanes on a valid/ready output stream. Sits between the FIFO read port and narrower user logic or the host stream. Sustains one narrow word per cycle with no bubble between wide words.

---
 rtl/fifo_stream_downsizer_if.sv | 24 ++
 rtl/fifo_stream_downsizer.sv | 92 +++++++++
 tb/tb_fifo_stream_downsizer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_downsizer_if.sv
// FWFT FIFO read port plus narrow valid/ready output stream of the downsizer.
// The master modport is the downsizer; the slave modport is the FIFO/sink side.
interface fifo_stream_downsizer_if #(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 32
);
  logic [IN_WIDTH-1:0]  fifo_dout;
  logic                 fifo_empty;
  logic                 fifo_rd_en;
  logic                 out_valid;
  logic                 out_rdy;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_last;

  modport master (
    input  fifo_dout, fifo_empty, out_rdy,
    output fifo_rd_en, out_valid, out_data, out_last
  );

  modport slave (
    output fifo_dout, fifo_empty, out_rdy,
    input  fifo_rd_en, out_valid, out_data, out_last
  );
endinterface

// File: rtl/fifo_stream_downsizer.sv
// Serializes FWFT wide words into RATIO lanes; first lane 1 cycle after pop, one lane/cycle, lanes hold under !out_rdy.
// Lane order is LSB first by default, MSB first when FIFO_DS_MSB_FIRST_EN is defined.
module fifo_stream_downsizer #(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  fifo_stream_downsizer_if.master        bus,
  output logic [31:0]                    word_count
);
  localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
  localparam int LANE_W = $clog2(RATIO);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  logic [0:0]           state_q, state_d;
  logic [IN_WIDTH-1:0]  buf_q, buf_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic [31:0]          word_count_q, word_count_d;

  logic                 buf_valid;
  logic                 last_lane;
  logic                 hs;
  logic                 pop;
  logic [OUT_WIDTH-1:0] lanes [RATIO];

  assign buf_valid = (state_q == ST_DRAIN);
  assign last_lane = (lane_q == LAST_LANE);
  assign hs        = buf_valid & bus.out_rdy;
  // Refill on the last-lane handshake so the next word follows without a bubble.
  assign pop       = ~bus.fifo_empty & ~flush & (~buf_valid | (hs & last_lane));

  for (genvar i = 0; i < RATIO; i++) begin : g_lane
`ifdef FIFO_DS_MSB_FIRST_EN
    assign lanes[i] = buf_q[IN_WIDTH-1-i*OUT_WIDTH -: OUT_WIDTH];
`else
    assign lanes[i] = buf_q[i*OUT_WIDTH +: OUT_WIDTH];
`endif
  end

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    buf_d        = buf_q;
    word_count_d = word_count_q;

    if (hs) begin
      word_count_d = word_count_q + 32'd1;
    end

    if (flush) begin
      state_d = ST_EMPTY;
      lane_d  = '0;
    end else if (pop) begin
      buf_d   = bus.fifo_dout;
      lane_d  = '0;
      state_d = ST_DRAIN;
    end else if (hs) begin
      if (last_lane) begin
        state_d = ST_EMPTY;
      end else begin
        lane_d = lane_q + LANE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      lane_q       <= '0;
      buf_q        <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      buf_q        <= buf_d;
      word_count_q <= word_count_d;
    end
  end

  assign bus.fifo_rd_en = pop;
  assign bus.out_valid  = buf_valid;
  assign bus.out_data   = lanes[lane_q];
  assign bus.out_last   = buf_valid & last_lane;
  assign word_count     = word_count_q;

endmodule

// File: tb/tb_fifo_stream_downsizer.sv
// Scoreboard bench: lanes are queued when a pop is seen and compared as the sink accepts them.
module tb_fifo_stream_downsizer;
  localparam int IW = 128;
  localparam int OW = 32;
  localparam int R  = IW / OW;

  typedef struct packed {
    logic [OW-1:0] d;
    logic          l;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] word_count;

  fifo_stream_downsizer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  fifo_stream_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (bus),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [IW-1:0] fq [$];
  exp_t          sbq [$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_pops  = 0;
  int            n_valid = 0;
  logic [31:0]   wc_exp  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh_fifo();
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_dout  = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic push_lanes(input logic [IW-1:0] w);
    exp_t e;
    int   li;
    for (int i = 0; i < R; i++) begin
`ifdef FIFO_DS_MSB_FIRST_EN
      li = R - 1 - i;
`else
      li = i;
`endif
      e.d = w[li*OW +: OW];
      e.l = (i == R - 1);
      sbq.push_back(e);
    end
  endtask

  // One clock: check outputs at the falling edge, then update the FIFO model after the rising edge.
  task automatic step();
    bit exp_v;
    bit exp_rd;
    @(negedge clk);
    chk("word_count", word_count, wc_exp);
    exp_v  = (sbq.size() != 0);
    exp_rd = !bus.fifo_empty && !flush && (!exp_v || (bus.out_rdy && sbq.size() == 1));
    chk("out_valid", bus.out_valid, exp_v);
    chk("out_last", bus.out_last, exp_v ? sbq[0].l : 1'b0);
    chk("fifo_rd_en", bus.fifo_rd_en, exp_rd);
    if (exp_v) begin
      chk("out_data", bus.out_data, sbq[0].d);
      n_valid++;
      if (bus.out_rdy) begin
        void'(sbq.pop_front());
        wc_exp++;
      end
    end
    if (flush) sbq.delete();
    if (exp_rd) begin
      push_lanes(fq[0]);
      n_pops++;
    end
    @(posedge clk);
    #1;
    if (exp_rd) void'(fq.pop_front());
    refresh_fifo();
  endtask

  task automatic drain(input string tag, output int n);
    n = 0;
    while ((sbq.size() != 0 || fq.size() != 0) && n < 200) begin
      step();
      n++;
    end
    chk(tag, (n < 200), 1'b1);
  endtask

  int            n;
  int            p0;
  int            v0;
  bit            rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [OW-1:0] lane0_exp;

  initial begin
    rst         = 1'b1;
    flush       = 1'b0;
    bus.out_rdy = 1'b0;
    refresh_fifo();

    #12;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_last", bus.out_last, 1'b0);
    chk("rst_data", bus.out_data, '0);
    chk("rst_rd_en", bus.fifo_rd_en, 1'b0);
    chk("rst_wc", word_count, 32'd0);
    rst = 1'b0;

    repeat (10) step();

    // Single word
    fq.push_back(128'h44444444_33333333_22222222_11111111);
    refresh_fifo();
    bus.out_rdy = 1'b1;
    p0 = n_pops;
    step();
`ifdef FIFO_DS_MSB_FIRST_EN
    lane0_exp = 32'h44444444;
`else
    lane0_exp = 32'h11111111;
`endif
    chk("single_lane0", bus.out_data, lane0_exp);
    drain("single_drain", n);
    chk("single_pops", n_pops - p0, 1);
    chk("single_wc", word_count, 32'd4);

    // Back-to-back
    for (int i = 0; i < 8; i++) fq.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
    refresh_fifo();
    p0 = n_pops;
    v0 = n_valid;
    drain("b2b_drain", n);
    chk("b2b_cycles", n, 33);
    chk("b2b_pops", n_pops - p0, 8);
    chk("b2b_valid", n_valid - v0, 32);
    chk("b2b_wc", word_count, 32'd36);

    // Backpressure
    for (int i = 0; i < 2; i++) fq.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
    refresh_fifo();
    n = 0;
    while ((sbq.size() != 0 || fq.size() != 0) && n < 200) begin
      bus.out_rdy = rdy_pat[n % 4];
      step();
      n++;
    end
    chk("bp_drain", (n < 200), 1'b1);
    chk("bp_wc", word_count, 32'd44);

    // Flush at lane 1
    for (int i = 0; i < 3; i++) fq.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
    refresh_fifo();
    bus.out_rdy = 1'b1;
    p0 = n_pops;
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid", bus.out_valid, 1'b0);
    drain("flush_drain", n);
    chk("flush_pops", n_pops - p0, 3);
    chk("flush_wc", word_count, 32'd54);

    // Async reset at lane 2
    for (int i = 0; i < 2; i++) fq.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
    refresh_fifo();
    step();
    step();
    step();
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", bus.out_valid, 1'b0);
    chk("arst_last", bus.out_last, 1'b0);
    chk("arst_wc", word_count, 32'd0);
    sbq.delete();
    wc_exp = 0;
    #1 rst = 1'b0;
    drain("arst_drain", n);
    chk("arst_wc_after", word_count, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
